estim_sample_seq: RTL and testbench

ESTIM_SAMPLE_SEQ -- requirements
Module: estim_sample_seq

---
 rtl/estim_seq_pkg.sv | 19 +
 rtl/estim_seq_timer.sv | 31 +++
 rtl/estim_sample_seq.sv | 193 +++++++++++++++++++
 tb/tb_estim_sample_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/estim_seq_pkg.sv
// Shared constants and state encoding for the estimator sample sequencer.
package estim_seq_pkg;

  localparam int unsigned P_DEF         = 32;
  localparam int unsigned AW_DEF        = 10;
  localparam int unsigned N_SAMPLES_DEF = 1000;
  localparam int unsigned TIMEOUT_DEF   = 1500;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_ACK     = 3'd5,
    ST_NEXT    = 3'd6
  } state_t;

endpackage

// File: rtl/estim_seq_timer.sv
// Handshake-phase cycle counter; saturates at TIMEOUT and flags the TIMEOUT-th enabled cycle.
module estim_seq_timer
  import estim_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TW'(TIMEOUT))) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  // r_cnt holds the number of completed enabled cycles, so this is the TIMEOUT-th one
  assign o_expired_c = i_en && (r_cnt >= TW'(TIMEOUT - 1));

endmodule

// File: rtl/estim_sample_seq.sv
// Streams sample pairs from memory to the estimator, handshakes each result and captures it.
module estim_sample_seq
  import estim_seq_pkg::*;
#(
  parameter int unsigned P         = P_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic [AW-1:0] o_mem_addr,
  input  logic [P-1:0]  i_mem_i,
  input  logic [P-1:0]  i_mem_v,
  output logic [P-1:0]  o_i,
  output logic [P-1:0]  o_v,
  output logic          o_ack_cas_i,
  output logic          o_ack_cas_v,
  input  logic          i_ack_theta_if,
  input  logic          i_ack_theta_vf,
  input  logic [P-1:0]  i_result_lin_i,
  input  logic [P-1:0]  i_result_v,
  output logic [P-1:0]  o_out_lin_i,
  output logic [P-1:0]  o_out_v,
  output logic [AW-1:0] o_out_idx,
  output logic          o_out_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_timeout_err
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [P-1:0]  r_i;
  logic [P-1:0]  r_v;
  logic [P-1:0]  r_out_lin_i;
  logic [P-1:0]  r_out_v;
  logic [AW-1:0] r_out_idx;
  logic          r_out_valid;
  logic          r_ack;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic w_start;
  logic w_load;
  logic w_capture;
  logic w_set_err;
  logic w_set_done;
  logic w_idx_inc;
  logic w_flags_hi;
  logic w_flags_lo;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expired;

  assign w_flags_hi = i_ack_theta_if && i_ack_theta_vf;
  assign w_flags_lo = !i_ack_theta_if && !i_ack_theta_vf;

  // Timer restarts on every state change and only runs in the two handshake phases
  assign w_tmr_clr = (r_state != w_state_nxt);
  assign w_tmr_en  = (r_state == ST_WAIT) || (r_state == ST_ACK);

  estim_seq_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_tmr_clr),
    .i_en        (w_tmr_en),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_set_err   = 1'b0;
    w_set_done  = 1'b0;
    w_idx_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start     = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A coincident result wins over the timeout
        if (w_flags_hi) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_CAPTURE;
        end else if (w_expired) begin
          w_set_err   = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_CAPTURE: w_state_nxt = ST_ACK;
      ST_ACK: begin
        if (w_flags_lo) begin
          w_state_nxt = ST_NEXT;
        end else if (w_expired) begin
          w_set_err   = 1'b1;
          w_state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (r_idx == AW'(N_SAMPLES - 1)) begin
          w_set_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_inc   = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx       <= '0;
      r_i         <= '0;
      r_v         <= '0;
      r_out_lin_i <= '0;
      r_out_v     <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_ack       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= w_capture;
      r_ack       <= (w_state_nxt == ST_ACK);
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_start) begin
        r_idx  <= '0;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_idx_inc) begin
        r_idx <= r_idx + AW'(1);
      end
      if (w_load) begin
        r_i <= i_mem_i;
        r_v <= i_mem_v;
      end
      if (w_capture) begin
        r_out_lin_i <= i_result_lin_i;
        r_out_v     <= i_result_v;
        r_out_idx   <= r_idx;
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (w_set_done) begin
        r_done <= 1'b1;
      end
    end
  end

  assign o_mem_addr    = r_idx;
  assign o_i           = r_i;
  assign o_v           = r_v;
  assign o_ack_cas_i   = r_ack;
  assign o_ack_cas_v   = r_ack;
  assign o_out_lin_i   = r_out_lin_i;
  assign o_out_v       = r_out_v;
  assign o_out_idx     = r_out_idx;
  assign o_out_valid   = r_out_valid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timeout_err = r_err;

endmodule

// File: tb/tb_estim_sample_seq.sv
// Directed bench for estim_sample_seq: full run, latency, timeout, held flags, mid-run reset.
module tb_estim_sample_seq;

  localparam int unsigned P       = 32;
  localparam int unsigned AW      = 10;
  localparam int unsigned NS      = 4;
  localparam int unsigned TMO     = 50;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [P-1:0]  mem_rd_i;
  logic [P-1:0]  mem_rd_v;
  logic [P-1:0]  dut_i;
  logic [P-1:0]  dut_v;
  logic          ack_cas_i;
  logic          ack_cas_v;
  logic          theta_if;
  logic          theta_vf;
  logic [P-1:0]  res_lin_i;
  logic [P-1:0]  res_v;
  logic [P-1:0]  out_lin_i;
  logic [P-1:0]  out_v;
  logic [AW-1:0] out_idx;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic          tmo_err;

  logic [P-1:0] mem_i [16];
  logic [P-1:0] mem_v [16];

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int snap;

  estim_sample_seq #(
    .P         (P),
    .AW        (AW),
    .N_SAMPLES (NS),
    .TIMEOUT   (TMO)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .o_mem_addr     (mem_addr),
    .i_mem_i        (mem_rd_i),
    .i_mem_v        (mem_rd_v),
    .o_i            (dut_i),
    .o_v            (dut_v),
    .o_ack_cas_i    (ack_cas_i),
    .o_ack_cas_v    (ack_cas_v),
    .i_ack_theta_if (theta_if),
    .i_ack_theta_vf (theta_vf),
    .i_result_lin_i (res_lin_i),
    .i_result_v     (res_v),
    .o_out_lin_i    (out_lin_i),
    .o_out_v        (out_v),
    .o_out_idx      (out_idx),
    .o_out_valid    (out_valid),
    .o_busy         (busy),
    .o_done         (done),
    .o_timeout_err  (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read sample memory
  always @(posedge clk) begin
    mem_rd_i <= mem_i[mem_addr[3:0]];
    mem_rd_v <= mem_v[mem_addr[3:0]];
  end

  always @(posedge clk) begin
    if (out_valid) n_valid++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] res_i_of(input int idx);
    return 32'hC000_0000 + 32'(idx);
  endfunction

  function automatic logic [31:0] res_v_of(input int idx);
    return 32'h4100_0000 + 32'(idx);
  endfunction

  // Entry: first WAIT cycle of sample idx. Flags rise 20 cycles after LOAD.
  task automatic do_sample(input int idx, input int hold, input bit pulse_start);
    check("iv_i", dut_i, mem_i[idx]);
    check("iv_v", dut_v, mem_v[idx]);
    for (int k = 0; k < 19; k++) begin
      if (pulse_start && k == 0) start = 1'b1;
      step();
      start = 1'b0;
    end
    check("wait_addr", 32'(mem_addr), 32'(idx));
    check("wait_busy", 32'(busy), 32'd1);
    check("no_early_valid", 32'(out_valid), 32'd0);
    theta_if  = 1'b1;
    theta_vf  = 1'b1;
    res_lin_i = res_i_of(idx);
    res_v     = res_v_of(idx);
    step();
    check("cap_valid", 32'(out_valid), 32'd1);
    check("cap_idx", 32'(out_idx), 32'(idx));
    check("cap_lin_i", out_lin_i, res_i_of(idx));
    check("cap_v", out_v, res_v_of(idx));
    step();
    check("ack_i_rise", 32'(ack_cas_i), 32'd1);
    check("ack_v_rise", 32'(ack_cas_v), 32'd1);
    check("valid_one_cycle", 32'(out_valid), 32'd0);
    for (int k = 0; k < hold; k++) begin
      step();
      check("ack_held", 32'({ack_cas_i, ack_cas_v}), 32'd3);
      check("held_no_valid", 32'(out_valid), 32'd0);
    end
    theta_if  = 1'b0;
    theta_vf  = 1'b0;
    res_lin_i = 32'hDEAD_BEEF;
    res_v     = 32'hDEAD_BEEF;
    step();
    check("ack_fall", 32'({ack_cas_i, ack_cas_v}), 32'd0);
    check("out_hold", out_lin_i, res_i_of(idx));
    step();
    if (idx == int'(NS) - 1) begin
      check("done_set", 32'(done), 32'd1);
      check("busy_clear", 32'(busy), 32'd0);
    end else begin
      check("next_addr", 32'(mem_addr), 32'(idx + 1));
      check("iv_stable", dut_i, mem_i[idx]);
      step();
      step();
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      mem_i[k] = 32'h3F80_0000 + 32'(k) * 32'h0001_0000;
      mem_v[k] = 32'h4000_0000 + 32'(k) * 32'h0001_0000;
    end
    rst       = 1'b1;
    start     = 1'b0;
    theta_if  = 1'b0;
    theta_vf  = 1'b0;
    res_lin_i = '0;
    res_v     = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_i", dut_i, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    step();
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Run A: full four-sample run, latency, held flags, ignored START
    n_valid = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    step();
    check("iv_not_yet", dut_i, 32'd0);
    step();
    check("lat3_i", dut_i, 32'h3F80_0000);
    check("lat3_v", dut_v, 32'h4000_0000);
    do_sample(0, 0, 1'b0);
    do_sample(1, 5, 1'b1);
    do_sample(2, 0, 1'b0);
    do_sample(3, 0, 1'b0);
    step();
    check("runA_pulses", 32'(n_valid), 32'd4);
    check("runA_done", 32'(done), 32'd1);
    check("runA_err", 32'(tmo_err), 32'd0);
    check("runA_idle", 32'(busy), 32'd0);

    // Run B: only one flag -> timeout, no capture, advance to idx 1
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_cleared", 32'(done), 32'd0);
    step();
    step();
    snap = n_valid;
    theta_if = 1'b1;
    repeat (TMO - 1) step();
    check("err_not_yet", 32'(tmo_err), 32'd0);
    step();
    check("err_set", 32'(tmo_err), 32'd1);
    check("tmo_ack", 32'(ack_cas_i), 32'd1);
    theta_if = 1'b0;
    step();
    step();
    check("tmo_no_valid", 32'(n_valid - snap), 32'd0);
    check("tmo_advance", 32'(mem_addr), 32'd1);
    step();
    step();
    do_sample(1, 0, 1'b0);
    check("err_sticky", 32'(tmo_err), 32'd1);

    // Mid-run asynchronous reset during WAIT of idx 2
    step();
    #3 rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_i", dut_i, 32'd0);
    check("mrst_out", out_lin_i, 32'd0);
    check("mrst_addr", 32'(mem_addr), 32'd0);
    check("mrst_err", 32'(tmo_err), 32'd0);
    #1 rst = 1'b0;
    step();
    step();
    step();
    check("post_rst_idle", 32'(busy), 32'd0);

    // Run C: fresh START restarts from idx 0
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("restart_addr", 32'(mem_addr), 32'd0);
    check("restart_i", dut_i, mem_i[0]);
    check("restart_busy", 32'(busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
